// File: rtl/game_pkg.sv
// Shared definitions for the hoop game round controller.
//   game_state_t  : round FSM encoding, also driven out on the state port
//   TIME_W        : width of the seconds-remaining value
//   SCORE_W       : width of the score value
//   SENSOR_W      : number of hoop switches
//   SCORE_MAX_DEF : default score saturation value
//   sat_inc()     : saturating increment used for the score
package game_pkg;

  localparam int TIME_W        = 8;
  localparam int SCORE_W       = 8;
  localparam int SENSOR_W      = 3;
  localparam int SCORE_MAX_DEF = 99;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    PLAY   = 3'd2,
    COMMIT = 3'd3,
    OVER   = 3'd4
  } game_state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                 input logic [SCORE_W-1:0] limit);
    if (value >= limit) return limit;
    return value + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_round_ctrl_hit_detector.sv
// Hoop sensor conditioning.
// Synchronizes the asynchronous hoop switches, ORs their rising edges and
// suppresses further hits for HIT_LOCKOUT cycles after each counted one.
//   clock  : system clock
//   reset  : asynchronous, active-low reset
//   sensor : raw hoop switch levels
//   hit    : one-cycle pulse, a new rising edge outside the lockout window
module hit_detector
  import game_pkg::*;
#(
  parameter int HIT_LOCKOUT = 25_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] sensor,
  output logic                hit
);

  localparam int LOCK_W = $clog2(HIT_LOCKOUT + 1);

  logic [SENSOR_W-1:0] sens_meta;
  logic [SENSOR_W-1:0] sens_sync;
  logic [SENSOR_W-1:0] sens_prev;
  logic [SENSOR_W-1:0] sens_rise;
  logic [LOCK_W-1:0]   lock_cnt;

  assign sens_rise = sens_sync & ~sens_prev;
  assign hit       = (|sens_rise) && (lock_cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sens_meta <= '0;
      sens_sync <= '0;
      sens_prev <= '0;
      lock_cnt  <= '0;
    end else begin
      sens_meta <= sensor;
      sens_sync <= sens_meta;
      sens_prev <= sens_sync;
      // Lockout window covers the hit cycle plus HIT_LOCKOUT-1 more cycles.
      if (hit)
        lock_cnt <= LOCK_W'(HIT_LOCKOUT - 1);
      else if (lock_cnt != '0)
        lock_cnt <= lock_cnt - LOCK_W'(1);
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the hoop game.
// Runs the round lifecycle, gates score counting to the play window and
// hands the final score to the leaderboard with a one-cycle commit pulse.
//   clock     : system clock
//   reset     : asynchronous, active-low reset
//   start     : start button level (asynchronous)
//   sensor    : hoop switch levels (asynchronous)
//   state     : current round state (game_state_t encoding)
//   time_left : seconds remaining in ARM or PLAY
//   score     : current round score
//   playing   : high in PLAY
//   game_over : high in OVER
//   lb_commit : one-cycle leaderboard capture strobe
//
// state  | meaning
// IDLE   | after reset, waiting for the first start press
// ARM    | get-ready countdown, hits ignored
// PLAY   | timed play, hits add to the score
// COMMIT | single cycle, leaderboard captures the score
// OVER   | round finished, score held until the next start press
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int ROUND_SECS  = 30,
  parameter int ARM_SECS    = 3,
  parameter int HIT_LOCKOUT = 25_000_000,
  parameter int SCORE_MAX   = SCORE_MAX_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [SENSOR_W-1:0] sensor,
  output logic [2:0]          state,
  output logic [TIME_W-1:0]   time_left,
  output logic [SCORE_W-1:0]  score,
  output logic                playing,
  output logic                game_over,
  output logic                lb_commit
);

  localparam int TICK_W = $clog2(TICK_CYCLES + 1);

  game_state_t         cur_st;
  game_state_t         nxt_st;
  logic [TIME_W-1:0]   time_nxt;
  logic [SCORE_W-1:0]  score_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   tick_cnt_nxt;
  logic                tick;
  logic                hit;
  logic                start_meta;
  logic                start_sync;
  logic                start_prev;
  logic                start_rise;

  hit_detector #(
    .HIT_LOCKOUT (HIT_LOCKOUT)
  ) u_hit_detector (
    .clock  (clock),
    .reset  (reset),
    .sensor (sensor),
    .hit    (hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_meta <= start;
      start_sync <= start_meta;
      start_prev <= start_sync;
    end
  end

  assign start_rise = start_sync & ~start_prev;
  assign tick       = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign state      = cur_st;

  always_comb begin
    nxt_st    = cur_st;
    time_nxt  = time_left;
    score_nxt = score;
    unique case (cur_st)
      IDLE, OVER: begin
        if (start_rise) begin
          nxt_st    = ARM;
          time_nxt  = TIME_W'(ARM_SECS);
          score_nxt = '0;
        end
      end
      ARM: begin
        if (tick) begin
          if (time_left == TIME_W'(1)) begin
            nxt_st   = PLAY;
            time_nxt = TIME_W'(ROUND_SECS);
          end else begin
            time_nxt = time_left - TIME_W'(1);
          end
        end
      end
      PLAY: begin
        // A hit on the final tick still lands before COMMIT.
        if (hit)
          score_nxt = sat_inc(score, SCORE_W'(SCORE_MAX));
        if (tick) begin
          if (time_left == TIME_W'(1)) begin
            nxt_st   = COMMIT;
            time_nxt = '0;
          end else begin
            time_nxt = time_left - TIME_W'(1);
          end
        end
      end
      COMMIT: nxt_st = OVER;
      default: begin
        nxt_st    = IDLE;
        time_nxt  = '0;
        score_nxt = '0;
      end
    endcase

    // Second timer restarts on every state entry so phase lengths are exact.
    if (nxt_st != cur_st || tick)
      tick_cnt_nxt = '0;
    else
      tick_cnt_nxt = tick_cnt + TICK_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_st    <= IDLE;
      time_left <= '0;
      score     <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      lb_commit <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      cur_st    <= nxt_st;
      time_left <= time_nxt;
      score     <= score_nxt;
      playing   <= (nxt_st == PLAY);
      game_over <= (nxt_st == OVER);
      lb_commit <= (nxt_st == COMMIT);
      tick_cnt  <= tick_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl.
// u_dut1 uses the small round parameters (TICK_CYCLES=4, ROUND_SECS=3,
// ARM_SECS=2, HIT_LOCKOUT=3, SCORE_MAX=5). A 12-cycle play window fits at
// most four locked-out hits, so saturation runs on u_dut2 with
// TICK_CYCLES=12 and otherwise identical parameters.
module tb_game_round_ctrl;
  import game_pkg::*;

  logic       clock;
  logic       reset;
  logic       start1, start2;
  logic [2:0] sensor1, sensor2;
  logic [2:0] state1, state2;
  logic [7:0] time_left1, time_left2;
  logic [7:0] score1, score2;
  logic       playing1, playing2;
  logic       game_over1, game_over2;
  logic       lb_commit1, lb_commit2;

  int n_tests = 0;
  int n_fail  = 0;
  int commits1 = 0;
  int stray_commits = 0;

  game_round_ctrl #(
    .TICK_CYCLES(4), .ROUND_SECS(3), .ARM_SECS(2), .HIT_LOCKOUT(3), .SCORE_MAX(5)
  ) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .sensor(sensor1),
    .state(state1), .time_left(time_left1), .score(score1),
    .playing(playing1), .game_over(game_over1), .lb_commit(lb_commit1)
  );

  game_round_ctrl #(
    .TICK_CYCLES(12), .ROUND_SECS(3), .ARM_SECS(2), .HIT_LOCKOUT(3), .SCORE_MAX(5)
  ) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .sensor(sensor2),
    .state(state2), .time_left(time_left2), .score(score2),
    .playing(playing2), .game_over(game_over2), .lb_commit(lb_commit2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (lb_commit1) commits1++;
    if (lb_commit1 && state1 != 3'(COMMIT)) stray_commits++;
    if (lb_commit2 && state2 != 3'(COMMIT)) stray_commits++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_st(input string tag, input bit sel, input logic [2:0] st, input int budget);
    int n = 0;
    while (((sel ? state2 : state1) != st) && n < budget) begin
      step();
      n++;
    end
    chk(tag, sel ? state2 : state1, st);
  endtask

  task automatic check_phase(input string tag, input logic [2:0] st, input int cycles, input int t0);
    for (int k = 0; k < cycles; k++) begin
      chk({tag, "_state"}, state1, st);
      chk({tag, "_time"}, time_left1, t0 - k / 4);
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, state1, 3'(IDLE));
    chk({tag, "_time"}, time_left1, 0);
    chk({tag, "_score"}, score1, 0);
    chk({tag, "_playing"}, playing1, 0);
    chk({tag, "_over"}, game_over1, 0);
    chk({tag, "_commit"}, lb_commit1, 0);
  endtask

  initial begin
    reset = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    sensor1 = 3'b000; sensor2 = 3'b000;

    // Reset and idle
    repeat (3) step();
    check_all_zero("in_reset");
    reset = 1'b1;
    repeat (4) step();
    check_all_zero("idle");

    // Round 1: no hits, exact phase lengths
    start1 = 1'b1;
    wait_st("r1_arm_entry", 1'b0, 3'(ARM), 8);
    start1 = 1'b0;
    chk("r1_arm_score", score1, 0);
    check_phase("r1_arm", 3'(ARM), 8, 2);
    chk("r1_play_flag", playing1, 1);
    check_phase("r1_play", 3'(PLAY), 12, 3);
    chk("r1_commit_state", state1, 3'(COMMIT));
    chk("r1_commit_pulse", lb_commit1, 1);
    chk("r1_commit_score", score1, 0);
    chk("r1_commit_time", time_left1, 0);
    chk("r1_commit_playing", playing1, 0);
    step();
    chk("r1_over_state", state1, 3'(OVER));
    chk("r1_over_flag", game_over1, 1);
    chk("r1_over_pulse", lb_commit1, 0);
    chk("r1_commit_count", commits1, 1);
    repeat (3) step();
    chk("r1_over_hold", state1, 3'(OVER));

    // Round 2: lockout, start ignored in PLAY, hit on the final tick
    start1 = 1'b1;
    wait_st("r2_arm_entry", 1'b0, 3'(ARM), 8);
    start1 = 1'b0;
    wait_st("r2_play_entry", 1'b0, 3'(PLAY), 10);
    for (int k = 0; k <= 13; k++) begin
      case (k)
        0:  sensor1 = 3'b001;
        1:  begin sensor1 = 3'b011; start1 = 1'b1; end
        3:  sensor1 = 3'b111;
        4:  start1 = 1'b0;
        5:  chk("r2_lockout_blocks", score1, 1);
        6:  chk("r2_after_lockout", score1, 2);
        7:  begin sensor1 = 3'b000; chk("r2_start_ignored", state1, 3'(PLAY)); end
        9:  sensor1 = 3'b001;
        11: chk("r2_before_final", score1, 2);
        12: begin
              chk("r2_final_commit", state1, 3'(COMMIT));
              chk("r2_final_pulse", lb_commit1, 1);
              chk("r2_final_score", score1, 3);
            end
        13: begin
              chk("r2_over_score", score1, 3);
              chk("r2_over_flag", game_over1, 1);
            end
        default: ;
      endcase
      if (k < 13) step();
    end
    sensor1 = 3'b000;
    chk("r2_commit_count", commits1, 2);

    // Round 3: restart from OVER, then async reset mid-PLAY
    start1 = 1'b1;
    wait_st("r3_arm_entry", 1'b0, 3'(ARM), 8);
    start1 = 1'b0;
    chk("r3_arm_score", score1, 0);
    chk("r3_arm_time", time_left1, 2);
    chk("r3_arm_over", game_over1, 0);
    wait_st("r3_play_entry", 1'b0, 3'(PLAY), 10);
    repeat (3) step();
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    step();
    reset = 1'b1;
    repeat (2) step();
    check_all_zero("after_reset");

    // Saturation and ARM hits on u_dut2
    start2 = 1'b1;
    wait_st("sat_arm_entry", 1'b1, 3'(ARM), 8);
    start2 = 1'b0;
    for (int j = 0; j < 24; j++) begin
      sensor2 = (j % 4 == 0 && j <= 8) ? 3'b100 : 3'b000;
      if (j == 20) chk("sat_arm_hits_ignored", score2, 0);
      step();
    end
    chk("sat_play_entry", state2, 3'(PLAY));
    for (int k = 0; k < 32; k++) begin
      sensor2 = (k % 4 == 0) ? 3'b001 : 3'b000;
      if (k == 12) chk("sat_partial", score2, 3);
      step();
    end
    sensor2 = 3'b000;
    chk("sat_state_play", state2, 3'(PLAY));
    chk("sat_score", score2, 5);
    wait_st("sat_commit_entry", 1'b1, 3'(COMMIT), 10);
    chk("sat_commit_pulse", lb_commit2, 1);
    chk("sat_commit_score", score2, 5);
    step();
    chk("sat_over_state", state2, 3'(OVER));
    chk("sat_over_score", score2, 5);

    chk("stray_commits", stray_commits, 0);
    chk("total_commits_dut1", commits1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
